// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier for the ALU MULT operation.
// Fixed WIDTH-cycle latency; BUSY stalls the pipeline until DONE.
module mult_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        prod_nxt = prod;
        if (mplier[0]) prod_nxt = prod + mcand;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            RESULT   <= '0;
            OVERFLOW <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        mcand  <= {{WIDTH{1'b0}}, DATA1};
                        mplier <= DATA2;
                        prod   <= '0;
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // last iteration: publish the completed product
                    if (cnt == LAST) begin
                        RESULT   <= prod_nxt[WIDTH-1:0];
                        OVERFLOW <= |prod_nxt[2*WIDTH-1:WIDTH];
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier that supplies the ALU's MULT operation (SELECT 3'b100).
- Sits beside the ALU: takes the same two register-file operands and returns an 8-bit product for the ALU result mux.
- Holds BUSY high while it works so the control unit can stall the PC and register-file write until DONE.
- Fixed, data-independent latency.

Parameters:
- WIDTH, 8, operand and result width in bits; internal product register is 2*WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- START  input  1  request a multiply; sampled only when the unit can accept (IDLE or DONE state).
- DATA1  input  WIDTH  multiplicand; captured on the accepting edge.
- DATA2  input  WIDTH  multiplier; captured on the accepting edge.
- RESULT  output  WIDTH  low WIDTH bits of the last completed product; registered.
- OVERFLOW  output  1  high if the upper WIDTH product bits of the last completed product are non-zero; registered.
- BUSY  output  1  high while a multiply is in progress.
- DONE  output  1  one-cycle pulse: RESULT and OVERFLOW have just updated.

Behaviour:
- Reset:
  - state IDLE; RESULT=0, OVERFLOW=0, BUSY=0, DONE=0.
  - Internal multiplicand, multiplier, product and counter cleared.
  - RESET has priority over START on the same edge.
  - RESET mid-operation aborts the multiply; no DONE pulse is produced.
- States:
  - IDLE: START=1 → RUN. Capture mcand={WIDTH zeros, DATA1}, mplier=DATA2, prod=0, cnt=0. START=0 → remain IDLE.
  - RUN (one iteration per edge):
    - if mplier[0], prod <= prod + mcand (2*WIDTH-bit, no carry out possible);
    - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
    - On the iteration where cnt == WIDTH-1: also load RESULT <= final prod[WIDTH-1:0] and OVERFLOW <= |final prod[2*WIDTH-1:WIDTH], then → DONE.
  - DONE (lasts exactly one cycle): START=1 → RUN with a fresh capture (back-to-back); START=0 → IDLE.
- Outputs per state: BUSY=1 exactly while in RUN; DONE=1 exactly while in DONE state.
- Latency: with START accepted at edge E0, BUSY is high during the WIDTH cycles after E0. RESULT is valid and DONE is high during the cycle after edge E0+WIDTH (8 cycles for the default WIDTH).
- Operand stability: DATA1 and DATA2 changes after the accepting edge have no effect.
- START while BUSY: ignored, not queued.
- RESULT and OVERFLOW hold their value until the next completion or RESET.
- Arithmetic:
  - Unsigned.
  - RESULT equals the low WIDTH bits of the two's-complement product, so it is correct for signed operands too.
  - OVERFLOW is defined for the unsigned interpretation only.
- No early termination, even for zero operands; latency is always WIDTH cycles.

Test Plan:
- RESET, then START with DATA1=5, DATA2=3 → BUSY high 8 cycles; then DONE=1 for one cycle, RESULT=15, OVERFLOW=0, BUSY=0.
- DATA1=20, DATA2=13 (product 260) → RESULT=8'h04, OVERFLOW=1. Then DATA1=255, DATA2=255 (16'hFE01) → RESULT=8'h01, OVERFLOW=1.
- DATA1=0, DATA2=200 → still 8 BUSY cycles; RESULT=0, OVERFLOW=0. DATA1=8'hFF (-1), DATA2=8'h02 → RESULT=8'hFE.
- Start 6×7; change DATA1/DATA2 and pulse START during cycles 3–5 of BUSY → RESULT=42; exactly one DONE pulse; no second operation starts.
- START held high continuously with 3×4 then 9×9 presented on the accepting edges → DONE pulses 9 cycles apart, RESULT=12 then 81, BUSY low only during each DONE cycle.
- Start 10×10; assert RESET on BUSY cycle 4 → next cycle BUSY=0, DONE=0, RESULT=0, OVERFLOW=0; no later DONE pulse. A fresh START 2×2 then gives RESULT=4.
